// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared constants for the round-robin FIFO pop scheduler: FSM state encoding
// and default sizing parameters.
// Optional feature macro used by the scheduler: ARB_WATCHDOG_EN.
// -----------------------------------------------------------------------------
package arb_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam int DEFAULT_NUM_FIFOS  = 4;
    localparam int DEFAULT_BURST      = 4;
    localparam int DEFAULT_WDOG_LIMIT = 16;

endpackage

// File: rtl/fifo_rr_scheduler_if.sv
// -----------------------------------------------------------------------------
// fifo_rr_scheduler_if
// Handshake bundle between the FIFO array / downstream sink and the scheduler.
//   en         : scheduler enable
//   empty      : per-FIFO empty flags
//   out_rdy    : downstream accepts data this cycle
//   req        : pop request
//   gnt_sel    : current owner index
//   gnt        : one-hot pop strobe
//   starve_err : sticky starvation flag (0 unless ARB_WATCHDOG_EN)
// Modports: slave = scheduler side, master = FIFO array / environment side.
// -----------------------------------------------------------------------------
interface fifo_rr_scheduler_if
    import arb_pkg::*;
#(
    parameter int NUM_FIFOS = DEFAULT_NUM_FIFOS,
    parameter int TAGWIDTH  = $clog2(NUM_FIFOS)
) ();

    logic                 en;
    logic [NUM_FIFOS-1:0] empty;
    logic                 out_rdy;
    logic                 req;
    logic [TAGWIDTH-1:0]  gnt_sel;
    logic [NUM_FIFOS-1:0] gnt;
    logic                 starve_err;

    modport master (
        output en, empty, out_rdy,
        input  req, gnt_sel, gnt, starve_err
    );

    modport slave (
        input  en, empty, out_rdy,
        output req, gnt_sel, gnt, starve_err
    );

endinterface

// File: rtl/rr_next_sel.sv
// -----------------------------------------------------------------------------
// rr_next_sel
// Combinational round-robin search: returns the first set bit of mask_i
// scanning start_i+1, start_i+2, ... modulo N. start_i itself is checked last,
// so it is chosen only when it is the sole set bit.
//   mask_i  : candidate mask (1 = non-empty)
//   start_i : index just before the first candidate
//   idx_o   : selected index (valid only with valid_o)
//   valid_o : any bit of mask_i set
// -----------------------------------------------------------------------------
module rr_next_sel
    import arb_pkg::*;
#(
    parameter int N  = DEFAULT_NUM_FIFOS,
    parameter int TW = $clog2(N)
) (
    input  logic [N-1:0]  mask_i,
    input  logic [TW-1:0] start_i,
    output logic [TW-1:0] idx_o,
    output logic          valid_o
);

    localparam logic [TW:0] N_L = (TW+1)'(N);

    logic [TW:0] cand;

    // Scan from the farthest offset down so the nearest hit is written last.
    // Wrap is done by subtraction so non-power-of-two N never yields idx >= N.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int k = N; k >= 1; k--) begin
            cand = {1'b0, start_i} + (TW+1)'(k);
            if (cand >= N_L) begin
                cand = cand - N_L;
            end
            if (mask_i[cand[TW-1:0]]) begin
                idx_o   = cand[TW-1:0];
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// -----------------------------------------------------------------------------
// fifo_rr_scheduler
// Round-robin pop scheduler for an array of NUM_FIFOS FIFOs. One owner is
// served for up to BURST consecutive pops, then ownership rotates to the next
// non-empty FIFO without a bubble.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fifo_rr_scheduler_if.slave (en, empty, out_rdy -> req, gnt_sel,
//           gnt, starve_err)
// Optional macro ARB_WATCHDOG_EN adds per-FIFO wait counters driving the
// sticky starve_err flag at WDOG_LIMIT; without it starve_err is tied 0.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no owner being served; pick first non-empty after rr_ptr
// GRANT | owner is popped whenever non-empty and out_rdy is high
// -----------------------------------------------------------------------------
module fifo_rr_scheduler
    import arb_pkg::*;
#(
    parameter int NUM_FIFOS  = DEFAULT_NUM_FIFOS,
    parameter int TAGWIDTH   = $clog2(NUM_FIFOS),
    parameter int BURST      = DEFAULT_BURST,
    parameter int WDOG_LIMIT = DEFAULT_WDOG_LIMIT
) (
    input  logic              clk,
    input  logic              rst_n,
    fifo_rr_scheduler_if.slave bus
);

    localparam int BW = $clog2(BURST + 1);
    localparam logic [BW-1:0]       BURST_LAST = BW'(BURST - 1);
    localparam logic [TAGWIDTH-1:0] LAST_IDX   = TAGWIDTH'(NUM_FIFOS - 1);

    logic [0:0]           state_q, state_d;
    logic [TAGWIDTH-1:0]  owner_q, owner_d;
    logic [TAGWIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]        burst_q, burst_d;

    logic                 owner_empty;
    logic                 req_w;
    logic [NUM_FIFOS-1:0] gnt_w;
    logic [TAGWIDTH-1:0]  sel_start;
    logic [TAGWIDTH-1:0]  sel_idx;
    logic                 sel_valid;

    assign owner_empty = bus.empty[owner_q];
    assign req_w       = bus.en & (state_q == ST_GRANT) & ~owner_empty & bus.out_rdy;

    always_comb begin
        gnt_w = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            gnt_w[i] = req_w & (owner_q == TAGWIDTH'(i));
        end
    end

    // One search unit serves both cases: from rr_ptr when idle, from the
    // current owner when rearbitrating inside GRANT.
    assign sel_start = (state_q == ST_IDLE) ? rr_ptr_q : owner_q;

    rr_next_sel #(
        .N  (NUM_FIFOS),
        .TW (TAGWIDTH)
    ) u_next_sel (
        .mask_i  (~bus.empty),
        .start_i (sel_start),
        .idx_o   (sel_idx),
        .valid_o (sel_valid)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        burst_d  = burst_q;
        if (!bus.en) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_IDLE) begin
            if (sel_valid) begin
                owner_d = sel_idx;
                burst_d = '0;
                state_d = ST_GRANT;
            end
        end else if (owner_empty || (req_w && (burst_q == BURST_LAST))) begin
            rr_ptr_d = owner_q;
            burst_d  = '0;
            if (sel_valid) begin
                owner_d = sel_idx;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (req_w) begin
            burst_d = burst_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= LAST_IDX;
            burst_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            burst_q  <= burst_d;
        end
    end

    assign bus.req     = req_w;
    assign bus.gnt     = gnt_w;
    assign bus.gnt_sel = owner_q;

`ifdef ARB_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_LIMIT + 1);
    localparam logic [WW-1:0] WD_MAX = WW'(WDOG_LIMIT);

    logic [WW-1:0] wait_q [NUM_FIFOS];
    logic [WW-1:0] wait_d [NUM_FIFOS];
    logic          starve_q, starve_d;

    // Counters saturate at the limit; the flag is raised on the same edge the
    // counter reaches it.
    always_comb begin
        starve_d = starve_q;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (bus.empty[i] || gnt_w[i]) begin
                wait_d[i] = '0;
            end else if (wait_q[i] != WD_MAX) begin
                wait_d[i] = wait_q[i] + 1'b1;
            end else begin
                wait_d[i] = wait_q[i];
            end
            if (wait_d[i] == WD_MAX) begin
                starve_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FIFOS; i++) begin
                wait_q[i] <= '0;
            end
            starve_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_FIFOS; i++) begin
                wait_q[i] <= wait_d[i];
            end
            starve_q <= starve_d;
        end
    end

    assign bus.starve_err = starve_q;
`else
    assign bus.starve_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_fifo_rr_scheduler
// Self-checking bench: table-driven round-robin sequence, hand-written corner
// sequences (solo FIFO, backpressure, async reset mid-burst, watchdog when
// ARB_WATCHDOG_EN is defined) and a randomized run against a queue-level
// reference model that tracks FIFO occupancies and whose turn it is.
// -----------------------------------------------------------------------------
module tb_fifo_rr_scheduler;

    localparam int N  = 4;
    localparam int TW = 2;
    localparam int B  = 4;
    localparam int WL = 16;

    typedef struct {
        bit           en;
        bit           rdy;
        logic [N-1:0] gnt;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    fifo_rr_scheduler_if #(.NUM_FIFOS(N), .TAGWIDTH(TW)) bus ();

    fifo_rr_scheduler #(
        .NUM_FIFOS  (N),
        .TAGWIDTH   (TW),
        .BURST      (B),
        .WDOG_LIMIT (WL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // FIFO occupancies and reference scheduling model
    int cnt [N];
    bit m_active;
    int m_cur;
    int m_last;
    int m_turn;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int next_ne(input int s);
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (s + k) % N;
            if (cnt[j] > 0) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_cur    = 0;
        m_last   = N - 1;
        m_turn   = 0;
    endtask

    task automatic drive_empty();
        for (int i = 0; i < N; i++) bus.empty[i] = (cnt[i] == 0);
    endtask

    // One clock: drive at negedge, check at negedge+1, advance model.
    task automatic cycle(input bit en_v, input bit rdy_v, output logic [N-1:0] obs);
        int           nxt;
        int           popped;
        bit           exp_req;
        logic [N-1:0] one;
        logic [N-1:0] exp_gnt;
        @(negedge clk);
        bus.en      = en_v;
        bus.out_rdy = rdy_v;
        drive_empty();
        #1;
        obs     = bus.gnt;
        one     = 1;
        exp_req = en_v && m_active && (cnt[m_cur] > 0) && rdy_v;
        exp_gnt = exp_req ? (one << m_cur) : '0;
        chk("req", int'(bus.req), int'(exp_req));
        chk("gnt", int'(bus.gnt), int'(exp_gnt));
        chk("gnt_sel", int'(bus.gnt_sel), m_cur);
        chk("gnt_onehot0", int'($onehot0(bus.gnt)), 1);
        chk("gnt_vs_empty", int'(|(bus.gnt & bus.empty)), 0);
`ifndef ARB_WATCHDOG_EN
        chk("starve_tied", int'(bus.starve_err), 0);
`endif
        popped = exp_req ? m_cur : -1;
        if (!en_v) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            nxt = next_ne(m_last);
            if (nxt >= 0) begin
                m_cur    = nxt;
                m_turn   = 0;
                m_active = 1'b1;
            end
        end else if (cnt[m_cur] == 0) begin
            m_last = m_cur;
            m_turn = 0;
            nxt    = next_ne(m_cur);
            if (nxt >= 0) m_cur = nxt;
            else          m_active = 1'b0;
        end else if (rdy_v) begin
            m_turn++;
            if (m_turn == B) begin
                m_last = m_cur;
                m_cur  = next_ne(m_cur);
                m_turn = 0;
            end
        end
        if (popped >= 0) cnt[popped]--;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        bus.en      = 1'b0;
        bus.out_rdy = 1'b0;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        drive_empty();
        model_reset();
        #1;
        chk("rst_req", int'(bus.req), 0);
        chk("rst_gnt", int'(bus.gnt), 0);
        chk("rst_gnt_sel", int'(bus.gnt_sel), 0);
        chk("rst_starve", int'(bus.starve_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        vec_t         tbl [38];
        logic [N-1:0] g;
        logic [N-1:0] one;

        // All FIFOs hold 8 entries: one idle bubble, then 4 pops each in turn.
        one    = 1;
        tbl[0] = '{1'b1, 1'b1, '0};
        for (int p = 0; p < 32; p++) tbl[1+p] = '{1'b1, 1'b1, one << ((p / 4) % N)};
        tbl[33] = '{1'b1, 1'b1, '0};
        for (int v = 34; v < 38; v++) tbl[v] = '{1'b0, 1'b1, '0};

        do_reset();
        for (int i = 0; i < N; i++) cnt[i] = 8;
        for (int v = 0; v < 38; v++) begin
            cycle(tbl[v].en, tbl[v].rdy, g);
            chk($sformatf("tbl%0d", v), int'(g), int'(tbl[v].gnt));
        end

        // Only FIFO 2 non-empty: burst limit keeps owner 2.
        do_reset();
        cnt[2] = 10;
        cycle(1'b1, 1'b1, g);
        chk("solo_bubble", int'(g), 0);
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 1'b1, g);
            chk($sformatf("solo_pop%0d", k), int'(g), 4);
        end
        cycle(1'b1, 1'b1, g);
        chk("solo_drained", int'(g), 0);

        // Backpressure at burst count 2: owner held, exactly 2 pops left.
        do_reset();
        for (int i = 0; i < N; i++) cnt[i] = 8;
        cycle(1'b1, 1'b1, g);
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 1'b1, g);
            chk("bp_pre", int'(g), 1);
        end
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 1'b0, g);
            chk("bp_hold_gnt", int'(g), 0);
            chk("bp_hold_owner", int'(bus.gnt_sel), 0);
        end
        for (int k = 0; k < 2; k++) begin
            cycle(1'b1, 1'b1, g);
            chk("bp_post", int'(g), 1);
        end
        cycle(1'b1, 1'b1, g);
        chk("bp_switch", int'(g), 2);

        // Asynchronous reset mid-burst on owner 3.
        do_reset();
        cnt[3] = 10;
        cycle(1'b1, 1'b1, g);
        cycle(1'b1, 1'b1, g);
        chk("ar_pop0", int'(g), 8);
        cycle(1'b1, 1'b1, g);
        chk("ar_pop1", int'(g), 8);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_gnt", int'(bus.gnt), 0);
        chk("ar_req", int'(bus.req), 0);
        chk("ar_sel", int'(bus.gnt_sel), 0);
        bus.en = 1'b0;
        model_reset();
        cnt[0] = 5;
        drive_empty();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b1, g);
        chk("ar_bubble", int'(g), 0);
        cycle(1'b1, 1'b1, g);
        chk("ar_first", int'(g), 1);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < N; i++) cnt[i] = int'($urandom_range(0, 6));
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                int f;
                f      = int'($urandom_range(0, N - 1));
                cnt[f] = cnt[f] + int'($urandom_range(1, 6));
            end
            cycle($urandom_range(0, 15) != 0, $urandom_range(0, 3) != 0, g);
        end

`ifdef ARB_WATCHDOG_EN
        // en low with FIFO 1 waiting: flag rises after 16 waiting cycles.
        do_reset();
        cnt[1] = 3;
        for (int k = 0; k < 22; k++) begin
            cycle(1'b0, 1'b1, g);
            chk($sformatf("wdog%0d", k), int'(bus.starve_err), (k >= 16) ? 1 : 0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_rr_scheduler.md
FIFO_RR_SCHEDULER -- requirements
Module: fifo_rr_scheduler

Interface
REQ-001 SHALL have parameter NUM_FIFOS, default 4, number of requesting FIFOs (2..16).
REQ-002 SHALL have parameter TAGWIDTH, default $clog2(NUM_FIFOS), width of the owner tag.
REQ-003 SHALL have parameter BURST, default 4, maximum consecutive pops granted to one owner (1..16).
REQ-004 SHALL have parameter WDOG_LIMIT, default 16, starvation threshold in cycles.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port en  input  1  scheduler enable.
REQ-008 SHALL have port empty  input  NUM_FIFOS  per-FIFO empty flags.
REQ-009 SHALL have port out_rdy  input  1  downstream accepts data this cycle.
REQ-010 SHALL have port req  output  1  pop request to the FIFO array.
REQ-011 SHALL have port gnt_sel  output  TAGWIDTH  current owner index.
REQ-012 SHALL have port gnt  output  NUM_FIFOS  one-hot pop, combinational: gnt[i] = req & (gnt_sel == i).
REQ-013 SHALL have port starve_err  output  1  sticky starvation flag (ARB_WATCHDOG_EN only; tied 0 otherwise).

Function
REQ-014 SHALL implement states IDLE and GRANT, with registers owner (TAGWIDTH), rr_ptr (TAGWIDTH), burst_cnt ($clog2(BURST+1)).
REQ-015 SHALL drive req = en & (state==GRANT) & !empty[owner] & out_rdy; gnt_sel = owner at all times.
REQ-016 SHALL guarantee gnt is zero or one-hot and never asserted for an empty FIFO, making a pop of an empty FIFO impossible.
REQ-017 SHALL, in IDLE with en high and any !empty, select the first non-empty index searching from rr_ptr+1 modulo NUM_FIFOS upward, load owner, clear burst_cnt, and enter GRANT next cycle.
REQ-018 SHALL, in GRANT, increment burst_cnt on each cycle where req is high.
REQ-019 SHALL rearbitrate when req is high and burst_cnt == BURST-1: set rr_ptr = owner; next owner = next non-empty after owner, excluding owner if any other FIFO is non-empty; otherwise keep owner; burst_cnt cleared.
REQ-020 SHALL rearbitrate the same way when empty[owner] is high in GRANT (one-cycle bubble); if all FIFOs are empty, enter IDLE.
REQ-021 SHALL hold owner and burst_cnt while out_rdy is low (no rearbitration on backpressure alone).
REQ-022 SHALL, when en goes low, force req low the same cycle, enter IDLE next cycle, and retain rr_ptr.
REQ-023 SHALL treat pointer wrap (NUM_FIFOS-1 -> 0) identically to any other increment; NUM_FIFOS not a power of two must never select an index >= NUM_FIFOS.

Reset
REQ-024 SHALL, on rst_n low, asynchronously set state=IDLE, owner=0, rr_ptr=NUM_FIFOS-1, burst_cnt=0, starve_err=0; req and gnt are 0 during reset.
REQ-025 SHALL resume with FIFO 0 as first candidate after reset deassertion, including reset mid-burst.

Configuration
REQ-026 SHALL support macro ARB_WATCHDOG_EN: when defined, a per-FIFO wait counter increments each cycle the FIFO is non-empty and not popped, clears on its pop or when empty, and sets starve_err when any counter reaches WDOG_LIMIT (cleared only by reset).
REQ-027 SHALL, without ARB_WATCHDOG_EN, contain no wait counters and tie starve_err to 0.

Structure
REQ-028 SHALL place state encoding (IDLE, GRANT) and default BURST/WDOG_LIMIT constants in shared package arb_pkg.
REQ-029 SHALL use one sub-module rr_next_sel (combinational: mask, start index -> next non-empty index and valid) instantiated for both IDLE and GRANT rearbitration.

Verification
REQ-030 SHALL cover: NUM_FIFOS=4, BURST=4, all FIFOs hold 8 entries, out_rdy=1 -> pops 0,0,0,0,(bubble-free switch) 1,1,1,1,2,... in order.
REQ-031 SHALL cover: only FIFO 2 non-empty with 10 entries -> 10 consecutive gnt=4'b0100 pops; burst limit keeps owner 2.
REQ-032 SHALL cover: out_rdy low for 5 cycles mid-burst at burst_cnt=2 -> gnt=0, owner unchanged; exactly 2 more pops after release before switching.
REQ-033 SHALL cover: rst_n pulsed low asynchronously mid-burst on owner 3 -> gnt=0 immediately; first grant after release goes to FIFO 0 if non-empty.
REQ-034 SHALL cover: ARB_WATCHDOG_EN, WDOG_LIMIT=16, en low for 20 cycles with FIFO 1 non-empty -> starve_err=1 on cycle 16 and stays set.
REQ-035 SHALL cover: formal properties -- gnt one-hot-or-zero, never gnt[i] & empty[i], every continuously non-empty FIFO popped within NUM_FIFOS*(BURST+1) cycles of en=1 and out_rdy=1.
